// File: rtl/reg_pkg.sv
// Shared definitions for the register file and the decode destination-select logic.
// Optional feature macro used by this slice: REG_FILE_BYPASS_EN.
package reg_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 3;
  localparam int CNT_W_DEF  = 4;

  typedef logic [ADDR_W_DEF-1:0] reg_addr_t;

  localparam reg_addr_t REG_ZERO = 3'd0;

endpackage

// File: rtl/reg_scoreboard.sv
// Pending-write scoreboard: busy vector, issue handshake, busy population and wb error flag.
// REG_FILE_BYPASS_EN lets a same-cycle write-back make a busy destination issuable.
module reg_scoreboard
  import reg_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    issue_valid_i,
  input  logic [ADDR_W-1:0]       issue_addr_i,
  output logic                    issue_ready_o,
  input  logic                    wb_valid_i,
  input  logic [ADDR_W-1:0]       wb_addr_i,
  output logic [(2**ADDR_W)-1:0]  busy_o,
  output logic [CNT_W-1:0]        pending_cnt_o,
  output logic                    wb_err_o
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DEPTH-1:0] busy_q, busy_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             issue_zero_s, wb_zero_s, fire_s;

  // Issue handshake; without bypass a same-cycle clear is deliberately not seen.
  always_comb begin
    issue_zero_s = (issue_addr_i == ADDR_W'(REG_ZERO));
    wb_zero_s    = (wb_addr_i == ADDR_W'(REG_ZERO));
`ifdef REG_FILE_BYPASS_EN
    issue_ready_o = issue_zero_s | ~busy_q[issue_addr_i]
                  | (wb_valid_i & (wb_addr_i == issue_addr_i));
`else
    issue_ready_o = issue_zero_s | ~busy_q[issue_addr_i];
`endif
    fire_s = issue_valid_i & issue_ready_o;
  end

  // Next busy vector: write-back clears first so a colliding issue leaves the bit set.
  always_comb begin
    busy_d = busy_q;
    if (wb_valid_i) begin
      busy_d[wb_addr_i] = 1'b0;
    end else begin
      busy_d[wb_addr_i] = busy_q[wb_addr_i];
    end
    if (fire_s) begin
      busy_d[issue_addr_i] = 1'b1;
    end else begin
      busy_d[issue_addr_i] = busy_d[issue_addr_i];
    end
    busy_d[0] = 1'b0;
    cnt_d = {CNT_W{1'b0}};
    for (int i = 1; i < DEPTH; i++) begin
      cnt_d = cnt_d + CNT_W'(busy_d[i]);
    end
    err_d = err_q | (wb_valid_i & ~wb_zero_s & ~busy_q[wb_addr_i]);
  end

  // Scoreboard state; reset drops every outstanding reservation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= {DEPTH{1'b0}};
      cnt_q  <= {CNT_W{1'b0}};
      err_q  <= 1'b0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      err_q  <= err_d;
    end
  end

  assign busy_o        = busy_q;
  assign pending_cnt_o = cnt_q;
  assign wb_err_o      = err_q;

endmodule

// File: rtl/reg_file_sb.sv
// Register file with pending-write scoreboard and two combinational read ports.
// Define REG_FILE_BYPASS_EN to forward same-cycle write-backs onto the read ports.
module reg_file_sb
  import reg_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  output logic              rs_busy,
  output logic              rt_busy,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_addr,
  output logic              issue_ready,
  input  logic              wb_valid,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic [CNT_W-1:0]  pending_cnt,
  output logic              wb_err
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DEPTH-1:0]  busy_s;
  logic              wb_nz_s;

  reg_scoreboard #(
    .ADDR_W (ADDR_W),
    .CNT_W  (CNT_W)
  ) u_sb (
    .clk           (clk),
    .rst_n         (rst_n),
    .issue_valid_i (issue_valid),
    .issue_addr_i  (issue_addr),
    .issue_ready_o (issue_ready),
    .wb_valid_i    (wb_valid),
    .wb_addr_i     (wb_addr),
    .busy_o        (busy_s),
    .pending_cnt_o (pending_cnt),
    .wb_err_o      (wb_err)
  );

  assign wb_nz_s = wb_valid & (wb_addr != ADDR_W'(REG_ZERO));

  // Data array; entry 0 is never written so it stays at its reset value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= {DATA_W{1'b0}};
      end
    end else if (wb_nz_s) begin
      regs_q[wb_addr] <= wb_data;
    end
  end

  // Read port A, with optional same-cycle forwarding of the write-back.
  always_comb begin
    rs_data = regs_q[rs_addr];
    rs_busy = busy_s[rs_addr];
    if (rs_addr == ADDR_W'(REG_ZERO)) begin
      rs_data = {DATA_W{1'b0}};
      rs_busy = 1'b0;
`ifdef REG_FILE_BYPASS_EN
    end else if (wb_nz_s && (wb_addr == rs_addr)) begin
      rs_data = wb_data;
      rs_busy = 1'b0;
`endif
    end else begin
      rs_data = regs_q[rs_addr];
      rs_busy = busy_s[rs_addr];
    end
  end

  // Read port B, identical in behaviour to port A.
  always_comb begin
    rt_data = regs_q[rt_addr];
    rt_busy = busy_s[rt_addr];
    if (rt_addr == ADDR_W'(REG_ZERO)) begin
      rt_data = {DATA_W{1'b0}};
      rt_busy = 1'b0;
`ifdef REG_FILE_BYPASS_EN
    end else if (wb_nz_s && (wb_addr == rt_addr)) begin
      rt_data = wb_data;
      rt_busy = 1'b0;
`endif
    end else begin
      rt_data = regs_q[rt_addr];
      rt_busy = busy_s[rt_addr];
    end
  end

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed bench for reg_file_sb: array/queue-level reference model checked every cycle plus literal expectations.
module tb_reg_file_sb;

`ifdef REG_FILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  rs_addr, rt_addr, issue_addr, wb_addr;
  logic [15:0] rs_data, rt_data, wb_data;
  logic        rs_busy, rt_busy, issue_valid, issue_ready, wb_valid, wb_err;
  logic [3:0]  pending_cnt;

  int n_vec = 0;
  int n_err = 0;

  logic [15:0] mreg [8];
  logic        mb   [8];
  logic        merr;

  reg_file_sb dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rs_addr     (rs_addr),
    .rt_addr     (rt_addr),
    .rs_data     (rs_data),
    .rt_data     (rt_data),
    .rs_busy     (rs_busy),
    .rt_busy     (rt_busy),
    .issue_valid (issue_valid),
    .issue_addr  (issue_addr),
    .issue_ready (issue_ready),
    .wb_valid    (wb_valid),
    .wb_addr     (wb_addr),
    .wb_data     (wb_data),
    .pending_cnt (pending_cnt),
    .wb_err      (wb_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] exp_data(input logic [2:0] a);
    if (a == 3'd0) return 16'd0;
    if (BYP && wb_valid && wb_addr == a) return wb_data;
    return mreg[a];
  endfunction

  function automatic logic exp_busy(input logic [2:0] a);
    if (a == 3'd0) return 1'b0;
    if (BYP && wb_valid && wb_addr == a) return 1'b0;
    return mb[a];
  endfunction

  function automatic logic exp_ready();
    return (issue_addr == 3'd0) || !mb[issue_addr] || (BYP && wb_valid && wb_addr == issue_addr);
  endfunction

  function automatic logic [3:0] exp_cnt();
    int c = 0;
    for (int i = 1; i < 8; i++) c += int'(mb[i]);
    return 4'(c);
  endfunction

  // Reference model: register contents, reservation set and sticky error.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) begin
        mreg[i] <= 16'd0;
        mb[i]   <= 1'b0;
      end
      merr <= 1'b0;
    end else begin
      if (wb_valid && wb_addr != 3'd0) begin
        if (!mb[wb_addr]) merr <= 1'b1;
        mreg[wb_addr] <= wb_data;
        mb[wb_addr]   <= 1'b0;
      end
      if (issue_valid && exp_ready() && issue_addr != 3'd0) mb[issue_addr] <= 1'b1;
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("rs_data", 32'(rs_data), 32'(exp_data(rs_addr)));
      chk("rt_data", 32'(rt_data), 32'(exp_data(rt_addr)));
      chk("rs_busy", 32'(rs_busy), 32'(exp_busy(rs_addr)));
      chk("rt_busy", 32'(rt_busy), 32'(exp_busy(rt_addr)));
      chk("issue_ready", 32'(issue_ready), 32'(exp_ready()));
      chk("pending_cnt", 32'(pending_cnt), 32'(exp_cnt()));
      chk("wb_err", 32'(wb_err), 32'(merr));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; rs_addr = 3'd0; rt_addr = 3'd0; issue_valid = 1'b0; issue_addr = 3'd0;
    wb_valid = 1'b0; wb_addr = 3'd0; wb_data = 16'd0;
    #1;
    chk("reset rs_data", 32'(rs_data), 32'd0);
    chk("reset pending", 32'(pending_cnt), 32'd0);
    chk("reset wb_err", 32'(wb_err), 32'd0);
    #7 rst_n = 1'b1;
    tick();

    // Issue r5, write back 0xBEEF three cycles later.
    rs_addr = 3'd5; rt_addr = 3'd5; issue_valid = 1'b1; issue_addr = 3'd5;
    #2 chk("issue r5 ready", 32'(issue_ready), 32'd1);
    tick(); issue_valid = 1'b0;
    #2 chk("r5 busy c1", 32'(rs_busy), 32'd1);
    chk("pending 1", 32'(pending_cnt), 32'd1);
    tick();
    #2 chk("r5 busy c2", 32'(rs_busy), 32'd1);
    tick();
    wb_valid = 1'b1; wb_addr = 3'd5; wb_data = 16'hBEEF;
    #2 chk("r5 wb-cycle data", 32'(rs_data), BYP ? 32'hBEEF : 32'h0);
    chk("r5 wb-cycle busy", 32'(rs_busy), BYP ? 32'd0 : 32'd1);
    tick(); wb_valid = 1'b0;
    #2 chk("r5 after wb", 32'(rs_data), 32'hBEEF);
    chk("pending 0", 32'(pending_cnt), 32'd0);

    // WAW hazard on r2.
    tick(); issue_valid = 1'b1; issue_addr = 3'd2; rs_addr = 3'd2;
    tick();
    #2 chk("waw ready", 32'(issue_ready), 32'd0);
    tick();
    #2 chk("waw busy kept", 32'(rs_busy), 32'd1);
    chk("waw pending", 32'(pending_cnt), 32'd1);
    issue_valid = 1'b0; wb_valid = 1'b1; wb_addr = 3'd2; wb_data = 16'h2222;
    #1 chk("waw wb-cycle ready", 32'(issue_ready), BYP ? 32'd1 : 32'd0);
    tick(); wb_valid = 1'b0;
    #2 chk("waw ready after wb", 32'(issue_ready), 32'd1);

    // Register zero is inert.
    tick(); issue_valid = 1'b1; issue_addr = 3'd0; wb_valid = 1'b1; wb_addr = 3'd0;
    wb_data = 16'hFFFF; rs_addr = 3'd0;
    #2 chk("r0 ready", 32'(issue_ready), 32'd1);
    tick(); issue_valid = 1'b0; wb_valid = 1'b0;
    #2 chk("r0 data", 32'(rs_data), 32'd0);
    chk("r0 pending", 32'(pending_cnt), 32'd0);
    chk("r0 wb_err", 32'(wb_err), 32'd0);

    // Spurious write-back to idle r4, then clean traffic on r6.
    tick(); wb_valid = 1'b1; wb_addr = 3'd4; wb_data = 16'h0001; rs_addr = 3'd4;
    tick(); wb_valid = 1'b0;
    #2 chk("spurious data", 32'(rs_data), 32'h1);
    chk("spurious err", 32'(wb_err), 32'd1);
    tick(); issue_valid = 1'b1; issue_addr = 3'd6; rt_addr = 3'd6;
    tick(); issue_valid = 1'b0; wb_valid = 1'b1; wb_addr = 3'd6; wb_data = 16'h0606;
    tick(); wb_valid = 1'b0;
    #2 chk("err sticky", 32'(wb_err), 32'd1);
    chk("r6 data", 32'(rt_data), 32'h0606);

    // Fill r1..r7, then refused issue plus write-back in one cycle.
    for (int r = 1; r < 8; r++) begin
      tick(); issue_valid = 1'b1; issue_addr = 3'(r);
    end
    tick(); issue_valid = 1'b0;
    #2 chk("fill pending", 32'(pending_cnt), 32'd7);
    issue_valid = 1'b1; issue_addr = 3'd1; wb_valid = 1'b1; wb_addr = 3'd7;
    wb_data = 16'h7777; rt_addr = 3'd7;
    #1 chk("full r1 ready", 32'(issue_ready), 32'd0);
    tick(); issue_valid = 1'b0; wb_valid = 1'b0;
    #2 chk("drain pending", 32'(pending_cnt), 32'd6);
    chk("r7 data", 32'(rt_data), 32'h7777);

    // Mid-run asynchronous reset with r3 = 0x1234 busy.
    wb_valid = 1'b1; wb_addr = 3'd3; wb_data = 16'h1234; rs_addr = 3'd3;
    tick(); wb_valid = 1'b0; issue_valid = 1'b1; issue_addr = 3'd3;
    tick(); issue_valid = 1'b0;
    #2 chk("r3 pre-reset data", 32'(rs_data), 32'h1234);
    chk("r3 pre-reset busy", 32'(rs_busy), 32'd1);
    rst_n = 1'b0;
    #1 chk("async rst rs_data", 32'(rs_data), 32'd0);
    chk("async rst rs_busy", 32'(rs_busy), 32'd0);
    chk("async rst pending", 32'(pending_cnt), 32'd0);
    chk("async rst wb_err", 32'(wb_err), 32'd0);
    @(negedge clk); #1 rst_n = 1'b1;
    tick(); wb_valid = 1'b1; wb_addr = 3'd3; wb_data = 16'h0003;
    tick(); wb_valid = 1'b0;
    #2 chk("post-reset wb err", 32'(wb_err), 32'd1);
    chk("post-reset r3", 32'(rs_data), 32'h3);
    tick(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
- 8-entry general register file with a per-register pending-write scoreboard.
- Decode presents the selected destination address at issue and sets that register busy.
- Write-back later delivers the result, writes the register and clears busy.
- Provides two combinational read ports (rs, rt) with busy flags so the pipeline can stall on RAW and WAW hazards.

Parameters:
- DATA_W, 16, register width in bits
- ADDR_W, 3, register address width; depth = 2**ADDR_W
- CNT_W, 4, width of pending_cnt; must hold 0..2**ADDR_W-1

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- rs_addr  in  ADDR_W  read port A address
- rt_addr  in  ADDR_W  read port B address
- rs_data  out  DATA_W  read port A data (combinational)
- rt_data  out  DATA_W  read port B data (combinational)
- rs_busy  out  1  register rs_addr has a pending write
- rt_busy  out  1  register rt_addr has a pending write
- issue_valid  in  1  decode requests destination reservation
- issue_addr  in  ADDR_W  destination register from decode destination select
- issue_ready  out  1  reservation can be accepted this cycle
- wb_valid  in  1  write-back result present
- wb_addr  in  ADDR_W  write-back destination
- wb_data  in  DATA_W  write-back value
- pending_cnt  out  CNT_W  number of busy registers
- wb_err  out  1  sticky: write-back hit a non-busy register

Behaviour:
- Reset (rst_n low, asynchronous): all registers 0, all busy bits 0, pending_cnt 0, wb_err 0. Read outputs then show 0 with busy 0.
- Register 0 always reads 0 and is never busy. Writes to it are discarded. An issue to it is accepted and has no effect.
- Reads are combinational from the array: rs_busy = busy[rs_addr], rt_busy = busy[rt_addr].
- issue_ready = ~busy[issue_addr], or 1 when issue_addr == 0. It is combinational and does not see a same-cycle write-back clear.
- Issue fire is issue_valid & issue_ready. On fire, busy[issue_addr] is set at the next edge.
- Write-back has no backpressure and is always accepted. When wb_valid is high:
  - reg[wb_addr] <= wb_data and busy[wb_addr] <= 0 at the edge.
  - If busy[wb_addr] was 0 and wb_addr != 0, wb_err <= 1. It is sticky until reset.
- Issue fire and write-back to the same address in the same cycle (only possible via an erroneous write-back): data is written, busy ends set (issue wins), and wb_err is set.
- pending_cnt tracks population of busy:
  - +1 on issue fire to a nonzero, non-busy address.
  - -1 on a write-back that clears a set bit.
  - Both in one cycle on different addresses: unchanged.
  - It never wraps, since the maximum is 2**ADDR_W-1.
- Latency: a write-back is visible on the read ports the cycle after wb_valid, unless the bypass option below is compiled in. Busy clear follows the same timing.
- Reset asserted mid-operation discards all pending reservations. Write-backs arriving after reset release are flagged wb_err.

Optional Feature:
- REG_FILE_BYPASS_EN defined: a write-back in the current cycle forwards combinationally.
  - If wb_valid and wb_addr == rs_addr != 0, rs_data = wb_data and rs_busy = 0. The rt port behaves the same way.
  - issue_ready additionally asserts when a same-cycle write-back clears issue_addr; busy then ends set.
- Not defined: reads return the pre-edge array contents, and issue_ready ignores same-cycle write-backs.

Decomposition:
- Shared package reg_pkg holds:
  - DATA_W and ADDR_W defaults
  - the REG_ZERO address constant
  - a reg_addr_t typedef shared with the decode destination-select logic
- One sub-module, reg_scoreboard, owns the busy vector, issue_ready, pending_cnt and wb_err.
- The top holds the data array and the read and bypass muxing.

Test Plan:
- Reset: rst_n=0 mid-run with r3=0x1234 busy -> rs_data=0, rs_busy=0, pending_cnt=0, wb_err=0 immediately, without waiting for a clock edge.
- Issue r5 then wb r5=0xBEEF after 3 cycles -> rs_busy=1 for 3 cycles, pending_cnt 1->0, rs_addr=5 reads 0xBEEF one cycle after wb, or in the same cycle with REG_FILE_BYPASS_EN.
- WAW: r2 busy, issue_valid with issue_addr=2 -> issue_ready=0, busy unchanged. After wb r2 -> issue_ready=1.
- r0: issue 0 and wb r0=0xFFFF -> issue_ready=1, pending_cnt stays 0, rs_data(0)=0, wb_err=0.
- Spurious wb r4=0x0001 with r4 not busy -> r4 reads 1, wb_err=1 and stays 1 across later clean traffic until reset.
- Fill r1..r7 busy -> pending_cnt=7. Simultaneous issue r1 (refused) and wb r7 -> pending_cnt=6, no wrap.
